// File: rtl/ps2_key_event.sv
// PS/2 keyboard receiver: synchronizes and debounces the keyboard clock, assembles
// 11-bit frames and turns set-2 make codes into one-cycle key events with an A-Z index.
module ps2_key_event #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kclk,
  input  logic       kdata,
  output logic       key_valid,
  output logic [7:0] scancode,
  output logic       is_letter,
  output logic [4:0] letter,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  logic          kclk_s1, kclk_s2, kdata_s1, kdata_s2;
  logic          kclk_f, kclk_f_d;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] idle_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift_p0;
  logic          start_p0, par_p0;
  logic [7:0]    byte_p1;
  logic          byte_vld_p1;
  logic          fall;
  state_t        state, state_nxt;
  logic [7:0]    held;
  logic          load_make, clr_held;

  // Set-2 make code -> {is_letter, index}; unmapped codes give all zero.
  function automatic logic [5:0] letter_map(input logic [7:0] code);
    logic [5:0] r;
    r = 6'd0;
    case (code)
      8'h1C: r = {1'b1, 5'd0};   8'h32: r = {1'b1, 5'd1};
      8'h21: r = {1'b1, 5'd2};   8'h23: r = {1'b1, 5'd3};
      8'h24: r = {1'b1, 5'd4};   8'h2B: r = {1'b1, 5'd5};
      8'h34: r = {1'b1, 5'd6};   8'h33: r = {1'b1, 5'd7};
      8'h43: r = {1'b1, 5'd8};   8'h3B: r = {1'b1, 5'd9};
      8'h42: r = {1'b1, 5'd10};  8'h4B: r = {1'b1, 5'd11};
      8'h3A: r = {1'b1, 5'd12};  8'h31: r = {1'b1, 5'd13};
      8'h44: r = {1'b1, 5'd14};  8'h4D: r = {1'b1, 5'd15};
      8'h15: r = {1'b1, 5'd16};  8'h2D: r = {1'b1, 5'd17};
      8'h1B: r = {1'b1, 5'd18};  8'h2C: r = {1'b1, 5'd19};
      8'h3C: r = {1'b1, 5'd20};  8'h2A: r = {1'b1, 5'd21};
      8'h1D: r = {1'b1, 5'd22};  8'h22: r = {1'b1, 5'd23};
      8'h35: r = {1'b1, 5'd24};  8'h1A: r = {1'b1, 5'd25};
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  assign fall = kclk_f_d & ~kclk_f;

  // Stage p0: synchronizers and kclk debounce
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kclk_s1  <= 1'b1;
      kclk_s2  <= 1'b1;
      kdata_s1 <= 1'b1;
      kdata_s2 <= 1'b1;
      kclk_f   <= 1'b1;
      kclk_f_d <= 1'b1;
      filt_cnt <= '0;
    end else begin
      kclk_s1  <= kclk;
      kclk_s2  <= kclk_s1;
      kdata_s1 <= kdata;
      kdata_s2 <= kdata_s1;
      kclk_f_d <= kclk_f;
      if (kclk_s2 == kclk_f) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        kclk_f   <= kclk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Stage p1: frame assembly, checking and idle timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt     <= 4'd0;
      idle_cnt    <= '0;
      shift_p0    <= 8'h00;
      start_p0    <= 1'b0;
      par_p0      <= 1'b0;
      byte_p1     <= 8'h00;
      byte_vld_p1 <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      byte_vld_p1 <= 1'b0;
      frame_err   <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (start_p0 || !(^{shift_p0, par_p0}) || !kdata_s2) begin
            frame_err <= 1'b1;
          end else begin
            byte_vld_p1 <= 1'b1;
            byte_p1     <= shift_p0;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd0)      start_p0 <= kdata_s2;
          else if (bit_cnt == 4'd9) par_p0   <= kdata_s2;
          else                      shift_p0 <= {kdata_s2, shift_p0[7:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        // A stalled partial frame is dropped silently; the byte FSM keeps its state.
        if (idle_cnt == TW'(TIMEOUT - 1)) begin
          bit_cnt  <= 4'd0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load_make = 1'b0;
    clr_held  = 1'b0;
    if (byte_vld_p1) begin
      case (state)
        IDLE: begin
          if (byte_p1 == 8'hF0)      state_nxt = BRK;
          else if (byte_p1 == 8'hE0) state_nxt = EXT;
          else if (byte_p1 != held)  load_make = 1'b1;
        end
        BRK: begin
          clr_held  = (byte_p1 == held);
          state_nxt = IDLE;
        end
        EXT:     state_nxt = (byte_p1 == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p2: byte FSM and key event outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      held      <= 8'h00;
      key_valid <= 1'b0;
      scancode  <= 8'h00;
      is_letter <= 1'b0;
      letter    <= 5'd0;
    end else begin
      state     <= state_nxt;
      key_valid <= load_make;
      if (load_make) begin
        held                <= byte_p1;
        scancode            <= byte_p1;
        {is_letter, letter} <= letter_map(byte_p1);
      end else if (clr_held) begin
        held <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_event.sv
// Bench for ps2_key_event: table of directed frames, hand-built corner sequences and
// random frames checked against a prefix-history model of the key decoding rules.
module tb_ps2_key_event;
  localparam int FL = 4;
  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kclk = 1'b1;
  logic       kdata = 1'b1;
  logic       key_valid, is_letter, frame_err;
  logic [7:0] scancode;
  logic [4:0] letter;

  ps2_key_event #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .kclk(kclk), .kdata(kdata),
    .key_valid(key_valid), .scancode(scancode), .is_letter(is_letter),
    .letter(letter), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Strobe monitor
  int         kv_cnt = 0, err_cnt = 0, kv_cyc = -1000, last_fall = 0;
  logic       kv_prev = 1'b0;
  always @(negedge clk) begin
    if (key_valid) begin
      kv_cnt++;
      kv_cyc = cyc;
      chk("kv_width", int'(kv_prev), 0);
    end
    if (frame_err) err_cnt++;
    kv_prev = key_valid;
  end

  task automatic send_bit(input logic b);
    @(negedge clk) kdata = b;
    repeat (5) @(negedge clk);
    kclk = 1'b0;
    last_fall = cyc;
    repeat (15) @(negedge clk);
    kclk = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] fr;
    logic        p;
    p  = bad ? (^b) : ~(^b);
    fr = {1'b1, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i]);
  endtask

  task automatic frame_check(input string name, input logic [7:0] b, input bit bad,
                             input bit ekv, input bit eerr, input logic [7:0] esc,
                             input bit eisl, input logic [4:0] eltr);
    int kv0, e0, lat;
    kv0 = kv_cnt;
    e0  = err_cnt;
    send_frame(b, bad, 11);
    repeat (20) @(negedge clk);
    chk({name, "_kv"}, kv_cnt - kv0, int'(ekv));
    chk({name, "_err"}, err_cnt - e0, int'(eerr));
    if (ekv) begin
      lat = kv_cyc - last_fall;
      checks++;
      if (lat < FL + 3 || lat > FL + 5) begin
        failures++;
        $display("FAIL %s_latency actual=%0d expected=%0d..%0d", name, lat, FL + 3, FL + 5);
      end
    end
    chk({name, "_sc"}, int'(scancode), int'(esc));
    chk({name, "_isl"}, int'(is_letter), int'(eisl));
    chk({name, "_ltr"}, int'(letter), int'(eltr));
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk) rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bad;
    bit         kv;
    bit         err;
    logic [7:0] sc;
    bit         isl;
    logic [4:0] ltr;
  } vec_t;

  logic [7:0] codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                             8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                             8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                             8'h35, 8'h1A};

  // Reference model state: pending prefix bytes and the currently held key.
  int         pfx[$];
  logic [7:0] m_held, m_sc;
  bit         m_isl;
  logic [4:0] m_ltr;

  task automatic model_step(input logic [7:0] b, input bit bad, output bit kv, output bit err);
    kv  = 1'b0;
    err = bad;
    if (bad) begin
      pfx.delete();
    end else if (pfx.size() == 0) begin
      if (b == 8'hF0 || b == 8'hE0) pfx.push_back(int'(b));
      else if (b != m_held) begin
        kv = 1'b1;
        m_held = b;
        m_sc = b;
        m_isl = 1'b0;
        m_ltr = 5'd0;
        for (int i = 0; i < 26; i++)
          if (codes[i] == b) begin
            m_isl = 1'b1;
            m_ltr = 5'(i);
          end
      end
    end else if (pfx.size() == 1 && pfx[0] == 'hF0) begin
      if (b == m_held) m_held = 8'h00;
      pfx.delete();
    end else if (pfx.size() == 1 && b == 8'hF0) begin
      pfx.push_back(int'(b));
    end else begin
      pfx.delete();
    end
  endtask

  vec_t tbl[$];

  initial begin
    int kv0, e0;
    bit ekv, eerr;
    logic [7:0] b;
    bit bad;
    int r;

    tbl.push_back('{8'h1C, 0, 1, 0, 8'h1C, 1, 5'd0});
    tbl.push_back('{8'hF0, 0, 0, 0, 8'h1C, 1, 5'd0});
    tbl.push_back('{8'h1C, 0, 0, 0, 8'h1C, 1, 5'd0});
    tbl.push_back('{8'h1C, 0, 1, 0, 8'h1C, 1, 5'd0});
    tbl.push_back('{8'h1C, 0, 0, 0, 8'h1C, 1, 5'd0});
    tbl.push_back('{8'h1C, 0, 0, 0, 8'h1C, 1, 5'd0});
    tbl.push_back('{8'hF0, 0, 0, 0, 8'h1C, 1, 5'd0});
    tbl.push_back('{8'h1C, 0, 0, 0, 8'h1C, 1, 5'd0});
    tbl.push_back('{8'h1C, 0, 1, 0, 8'h1C, 1, 5'd0});
    tbl.push_back('{8'h15, 1, 0, 1, 8'h1C, 1, 5'd0});
    tbl.push_back('{8'h15, 0, 1, 0, 8'h15, 1, 5'd16});
    tbl.push_back('{8'hE0, 0, 0, 0, 8'h15, 1, 5'd16});
    tbl.push_back('{8'h75, 0, 0, 0, 8'h15, 1, 5'd16});
    tbl.push_back('{8'hE0, 0, 0, 0, 8'h15, 1, 5'd16});
    tbl.push_back('{8'hF0, 0, 0, 0, 8'h15, 1, 5'd16});
    tbl.push_back('{8'h75, 0, 0, 0, 8'h15, 1, 5'd16});
    tbl.push_back('{8'h29, 0, 1, 0, 8'h29, 0, 5'd0});

    repeat (4) @(negedge clk);
    chk("rst_kv", int'(key_valid), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_sc", int'(scancode), 0);
    chk("rst_isl", int'(is_letter), 0);
    chk("rst_ltr", int'(letter), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    foreach (tbl[i])
      frame_check($sformatf("vec%0d", i), tbl[i].b, tbl[i].bad, tbl[i].kv, tbl[i].err,
                  tbl[i].sc, tbl[i].isl, tbl[i].ltr);

    // Short kclk glitch while idle must not start a frame
    kclk = 1'b0;
    repeat (2) @(negedge clk);
    kclk = 1'b1;
    repeat (20) @(negedge clk);
    frame_check("glitch32", 8'h32, 0, 1, 0, 8'h32, 1, 5'd1);

    // Partial frame abandoned by timeout
    e0 = err_cnt;
    send_frame(8'h1A, 0, 5);
    repeat (TO + 10) @(negedge clk);
    chk("timeout_noerr", err_cnt - e0, 0);
    frame_check("timeout1A", 8'h1A, 0, 1, 0, 8'h1A, 1, 5'd25);

    // Reset in the middle of a frame
    kv0 = kv_cnt;
    e0  = err_cnt;
    send_frame(8'h4D, 0, 6);
    pulse_reset(1);
    chk("midrst_sc", int'(scancode), 0);
    chk("midrst_isl", int'(is_letter), 0);
    chk("midrst_ltr", int'(letter), 0);
    chk("midrst_kv", int'(key_valid), 0);
    repeat (20) @(negedge clk);
    chk("midrst_strobes", (kv_cnt - kv0) + (err_cnt - e0), 0);
    frame_check("midrst4D", 8'h4D, 0, 1, 0, 8'h4D, 1, 5'd15);

    // Random frames against the model
    pulse_reset(3);
    repeat (10) @(negedge clk);
    m_held = 8'h00; m_sc = 8'h00; m_isl = 1'b0; m_ltr = 5'd0;
    pfx.delete();
    b = 8'h1C;
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      b = 8'hF0;
      else if (r == 1) b = 8'hE0;
      else if (r < 6)  b = codes[$urandom_range(0, 25)];
      else if (r < 8)  b = m_held;
      else             b = 8'($urandom_range(1, 255));
      if (b == 8'h00) b = 8'h1D;
      bad = ($urandom_range(0, 7) == 0);
      model_step(b, bad, ekv, eerr);
      frame_check($sformatf("rnd%0d_%02h", n, b), b, bad, ekv, eerr, m_sc, m_isl, m_ltr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
